// File: rtl/restador_simd.sv
// Lane-parallel unsigned subtractor with optional saturate-to-zero on borrow.
// Two-stage valid/ready pipeline: low half plus mid borrow first, high half and saturation second.
module restador_simd #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [LANES-1:0]       bin,
  input  logic                   sat,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] d,
  output logic [LANES-1:0]       bout
);

  localparam int LO = WIDTH / 2;
  localparam int HI = WIDTH - LO;

  logic                v1;
  logic                v2;
  logic                adv2;
  logic                s1_sat;
  logic [LANES*LO-1:0] s1_lo;
  logic [LANES-1:0]    s1_brw;
  logic [LANES*HI-1:0] s1_ahi;
  logic [LANES*HI-1:0] s1_bhi;

  logic [LANES*LO-1:0]    lo_next;
  logic [LANES-1:0]       brw_next;
  logic [LANES*HI-1:0]    ahi_next;
  logic [LANES*HI-1:0]    bhi_next;
  logic [LANES*WIDTH-1:0] d_next;
  logic [LANES-1:0]       bout_next;

  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LO:0] lo_diff;
    logic [HI:0] hi_diff;

    // The extra top bit of each partial difference is that half's borrow-out.
    assign lo_diff = {1'b0, a[i*WIDTH +: LO]} - {1'b0, b[i*WIDTH +: LO]}
                   - {{LO{1'b0}}, bin[i]};
    assign lo_next[i*LO +: LO]  = lo_diff[LO-1:0];
    assign brw_next[i]          = lo_diff[LO];
    assign ahi_next[i*HI +: HI] = a[i*WIDTH+LO +: HI];
    assign bhi_next[i*HI +: HI] = b[i*WIDTH+LO +: HI];

    assign hi_diff = {1'b0, s1_ahi[i*HI +: HI]} - {1'b0, s1_bhi[i*HI +: HI]}
                   - {{HI{1'b0}}, s1_brw[i]};
    assign bout_next[i] = hi_diff[HI];
    assign d_next[i*WIDTH +: WIDTH] = (s1_sat && hi_diff[HI]) ? '0
                                    : {hi_diff[HI-1:0], s1_lo[i*LO +: LO]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      s1_sat <= 1'b0;
      s1_lo  <= '0;
      s1_brw <= '0;
      s1_ahi <= '0;
      s1_bhi <= '0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_ready && in_valid) begin
        s1_sat <= sat;
        s1_lo  <= lo_next;
        s1_brw <= brw_next;
        s1_ahi <= ahi_next;
        s1_bhi <= bhi_next;
      end
    end
  end

  // Data only moves with a real vector so d/bout never change while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      d    <= '0;
      bout <= '0;
    end else begin
      if (adv2) v2 <= v1;
      if (adv2 && v1) begin
        d    <= d_next;
        bout <= bout_next;
      end
    end
  end

endmodule

// File: tb/tb_restador_simd.sv
// Self-checking bench for restador_simd (WIDTH=8, LANES=4): table vectors, corner sequences,
// and a randomized stream scored against an arithmetic lane model.
module tb_restador_simd;

  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [L*W-1:0] a;
  logic [L*W-1:0] b;
  logic [L-1:0]   bin;
  logic           sat;
  logic           out_valid;
  logic           out_ready;
  logic [L*W-1:0] d;
  logic [L-1:0]   bout;

  restador_simd #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .d(d), .bout(bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  bin;
    logic        sat;
    logic [31:0] d;
    logic [3:0]  bout;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  bout;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_fire   = 0;
  int          cyc      = 0;
  bit          strict_lat = 1'b1;
  bit          hist_ok    = 1'b0;
  logic        prev_stall, prev_ov;
  logic [31:0] prev_d;
  logic [3:0]  prev_bout;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per lane: signed difference a - b - bin; negative means borrow.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic [3:0] mbin,
                       input logic msat, output logic [31:0] md, output logic [3:0] mbo);
    md  = '0;
    mbo = '0;
    for (int i = 0; i < L; i++) begin
      int diff;
      diff = int'(ma[i*W +: W]) - int'(mb[i*W +: W]) - int'(mbin[i]);
      mbo[i] = (diff < 0);
      if (msat && diff < 0) md[i*W +: W] = 8'h00;
      else                  md[i*W +: W] = 8'((diff + 256) % 256);
    end
  endtask

  // One clock cycle: drive at negedge, evaluate handshakes, advance to next negedge.
  task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [3:0] ibin, input logic isat, input logic ordy,
                       input logic [31:0] ed, input logic [3:0] ebo, output logic acc);
    exp_t e;
    in_valid  = iv;
    a         = iv ? ia : $urandom;
    b         = iv ? ib : $urandom;
    bin       = iv ? ibin : 4'($urandom);
    sat       = iv ? isat : 1'($urandom);
    out_ready = ordy;
    #1;
    if (hist_ok && prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_d", d, prev_d);
      chk("stall_bout", bout, prev_bout);
    end else if (hist_ok && !prev_ov && !out_valid) begin
      chk("idle_hold_d", d, prev_d);
      chk("idle_hold_bout", bout, prev_bout);
    end
    if (out_valid && out_ready) begin
      n_fire++;
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("d", d, e.d);
        chk("bout", bout, e.bout);
        if (strict_lat) chk("latency", cyc - e.acc, 2);
        else            chk("latency_min", (cyc - e.acc) >= 2, 1);
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e.d = ed; e.bout = ebo; e.acc = cyc;
      q.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    prev_ov    = out_valid;
    prev_d     = d;
    prev_bout  = bout;
    hist_ok    = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
  endtask

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc;
    logic [31:0] ra, rb, md;
    logic [3:0]  rbin, mbo;
    logic        rsat;
    vec_t        bp[4];
    int          idx, fires0;

    tbl[0] = '{32'h10101001, 32'h01010101, 4'h0, 1'b0, 32'h0F0F0F00, 4'h0};
    tbl[1] = '{32'h00000000, 32'h01010101, 4'hF, 1'b0, 32'hFEFEFEFE, 4'hF};
    tbl[2] = '{32'h00000000, 32'h01010101, 4'hF, 1'b1, 32'h00000000, 4'hF};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 1'b0, 32'hFFFFFFFF, 4'hF};
    tbl[4] = '{32'h7F80FF00, 32'h807F00FF, 4'b0100, 1'b0, 32'hFF00FF01, 4'b1001};
    tbl[5] = '{32'h7F80FF00, 32'h807F00FF, 4'b0100, 1'b1, 32'h0000FF00, 4'b1001};
    tbl[6] = '{32'h12345678, 32'h11111111, 4'h0, 1'b0, 32'h01234567, 4'h0};

    // Reset held with traffic offered and clock running.
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    a = 32'hDEADBEEF; b = 32'h12345678; bin = 4'hF; sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_d", d, 0);
      chk("rst_bout", bout, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, single vectors with idle gaps, strict 2-cycle latency.
    strict_lat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle(1, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].sat, 1, tbl[i].d, tbl[i].bout, acc);
      chk("tbl_accept", acc, 1);
      idle(3);
    end

    // Backpressure: 4 vectors offered, consumer stalled for 3 cycles.
    strict_lat = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bp[i].a = $urandom; bp[i].b = $urandom; bp[i].bin = 4'($urandom); bp[i].sat = 1'($urandom);
      model(bp[i].a, bp[i].b, bp[i].bin, bp[i].sat, bp[i].d, bp[i].bout);
    end
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      cycle(1, bp[idx].a, bp[idx].b, bp[idx].bin, bp[idx].sat, 0, bp[idx].d, bp[idx].bout, acc);
      if (acc) idx++;
    end
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready_low", in_ready, 0);
    fires0 = n_fire;
    for (int c = 0; c < 4; c++) begin
      if (idx < 4) begin
        cycle(1, bp[idx].a, bp[idx].b, bp[idx].bin, bp[idx].sat, 1, bp[idx].d, bp[idx].bout, acc);
        if (acc) idx++;
      end else begin
        cycle(0, 0, 0, 0, 0, 1, 0, 0, acc);
      end
    end
    chk("bp_all_accepted", idx, 4);
    chk("bp_one_per_cycle", n_fire - fires0, 4);
    idle(3);

    // Reset mid-stream with both stages full.
    model(32'h01020304, 32'h01010101, 4'h0, 1'b0, md, mbo);
    cycle(1, 32'h01020304, 32'h01010101, 4'h0, 1'b0, 0, md, mbo, acc);
    cycle(1, 32'h05060708, 32'h01010101, 4'h0, 1'b0, 0, md, mbo, acc);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_bout", bout, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    hist_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    strict_lat = 1'b1;
    fires0 = n_fire;
    model(32'hA0B0C0D0, 32'h0A0B0C0D, 4'h5, 1'b1, md, mbo);
    cycle(1, 32'hA0B0C0D0, 32'h0A0B0C0D, 4'h5, 1'b1, 1, md, mbo, acc);
    idle(5);
    chk("post_rst_one_result", n_fire - fires0, 1);

    // Randomized stream with random backpressure.
    strict_lat = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ra = $urandom; rb = $urandom; rbin = 4'($urandom); rsat = 1'($urandom);
      if ($urandom_range(0, 3) == 0) ra[7:0] = rb[7:0];
      model(ra, rb, rbin, rsat, md, mbo);
      cycle($urandom_range(0, 3) != 0, ra, rb, rbin, rsat, $urandom_range(0, 3) != 0, md, mbo, acc);
    end
    idle(6);
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
